ram_arbiter: RTL

- Two-requester round-robin controller in front of the 32x8 single-port RAM; it owns every RAM command pin.
- After reset it runs an init sweep that writes INIT_VAL to every location, so the RAM never holds undefined data.
- After the sweep it grants at most one access per cycle, alternating between requesters under contention.
- Read data is captured from the RAM's registered output and returned per requester with a valid pulse.

---
 rtl/ram_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/ram_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM arbiter: FSM state, requester id and the read-return tag.
// Pure declarations, no logic.
package ram_arb_pkg;

    localparam int RAM_ADDR_W = 5;
    localparam int RAM_DATA_W = 8;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_id_t;

    // One entry of the read-return pipeline: which port the RAM data belongs to.
    typedef struct packed {
        logic     valid;
        port_id_t port;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; combinational gnt, zero latency.
// Requests are never dropped: a losing or blocked (advance=0) requester simply waits.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic advance,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b
);

    port_id_t last_winner;

    // Under contention the port that did not win last time takes the slot.
    always_comb begin
        gnt_a = advance && req_a && (!req_b || (last_winner == PORT_B));
        gnt_b = advance && req_b && (!req_a || (last_winner == PORT_A));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= PORT_B;
        end else if (gnt_a) begin
            last_winner <= PORT_A;
        end else if (gnt_b) begin
            last_winner <= PORT_B;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin front end for a single-port RAM with post-reset init sweep; reads return 2 cycles after grant.
// Requests are held off (not dropped) during the sweep and while the other port owns the cycle.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int                 ADDR_W   = RAM_ADDR_W,
    parameter int                 DATA_W   = RAM_DATA_W,
    parameter int                 DEPTH    = 32,
    parameter int                 INIT_EN  = 1,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,

    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              busy,

    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    output logic              ram_write_enb,
    output logic              ram_read_enb,
    input  logic [DATA_W-1:0] ram_data_out
);

    arb_state_t        state;
    logic [ADDR_W-1:0] init_ptr;
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;
    logic              advance;
    rd_tag_t           tag_new;
    rd_tag_t           tag_s1;
    rd_tag_t           tag_s2;

    assign advance = (state == SERVE) && !reset;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .req_a   (req_a),
        .req_b   (req_b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    // RAM command mux: sweep during INIT, granted port during SERVE, otherwise idle
    // with address/data parked on their last driven value.
    always_comb begin
        ram_address   = last_addr;
        ram_data_in   = last_data;
        ram_write_enb = 1'b0;
        ram_read_enb  = 1'b0;
        if (!reset) begin
            if (state == INIT) begin
                ram_address   = init_ptr;
                ram_data_in   = INIT_VAL;
                ram_write_enb = 1'b1;
            end else if (gnt_a) begin
                ram_address   = addr_a;
                ram_data_in   = wdata_a;
                ram_write_enb = we_a;
                ram_read_enb  = !we_a;
            end else if (gnt_b) begin
                ram_address   = addr_b;
                ram_data_in   = wdata_b;
                ram_write_enb = we_b;
                ram_read_enb  = !we_b;
            end
        end
    end

    always_comb begin
        tag_new.valid = ram_read_enb;
        tag_new.port  = gnt_b ? PORT_B : PORT_A;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr <= '0;
            last_data <= '0;
        end else if (ram_write_enb || ram_read_enb) begin
            last_addr <= ram_address;
            last_data <= ram_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (INIT_EN != 0) ? INIT : SERVE;
            busy     <= (INIT_EN != 0);
            init_ptr <= '0;
        end else begin
            case (state)
                INIT: begin
                    init_ptr <= init_ptr + ADDR_W'(1);
                    if (init_ptr == ADDR_W'(DEPTH - 1)) begin
                        state <= SERVE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= SERVE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // ram_data_out is only looked at in the cycle after a read command; reset
    // empties both stages so in-flight reads never return.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_s1  <= '0;
            tag_s2  <= '0;
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            tag_s1 <= tag_new;
            tag_s2 <= tag_s1;
            if (tag_s1.valid) begin
                if (tag_s1.port == PORT_A) begin
                    rdata_a <= ram_data_out;
                end else begin
                    rdata_b <= ram_data_out;
                end
            end
        end
    end

    assign rvalid_a = tag_s2.valid && (tag_s2.port == PORT_A);
    assign rvalid_b = tag_s2.valid && (tag_s2.port == PORT_B);

endmodule
